// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU and the load/store unit.
// Each producer pushes {value, ROB tag} into its own small FIFO. A round-robin arbiter
// pops at most one entry per cycle into the registered CDB broadcast.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   rdy_in                      global enable (low freezes all state)
//   need_flush_in               mispredict flush, empties both queues
//   alu_* / mem_*               producer handshakes (valid/value/tag in, ready out)
//   cdb_valid/value/tag/src_out registered broadcast (src 0 = ALU, 1 = LSB)
//   stall_cnt_out               saturating count of cycles with a refused offer
module cdb_arbiter #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int FIFO_DEPTH     = 2,
  parameter int PERF_WIDTH     = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      alu_valid_in,
  input  logic [31:0]               alu_value_in,
  input  logic [ROB_SIZE_WIDTH:0]   alu_tag_in,
  output logic                      alu_ready_out,
  input  logic                      mem_valid_in,
  input  logic [31:0]               mem_value_in,
  input  logic [ROB_SIZE_WIDTH:0]   mem_tag_in,
  output logic                      mem_ready_out,
  output logic                      cdb_valid_out,
  output logic [31:0]               cdb_value_out,
  output logic [ROB_SIZE_WIDTH:0]   cdb_tag_out,
  output logic                      cdb_src_out,
  output logic [PERF_WIDTH-1:0]     stall_cnt_out
);
  localparam int TW = ROB_SIZE_WIDTH + 1;
  localparam int EW = 32 + TW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Index 0 = ALU queue, index 1 = LSB queue.
  logic [EW-1:0]         buf_q   [2][FIFO_DEPTH];
  logic [EW-1:0]         buf_d   [2][FIFO_DEPTH];
  logic [PW-1:0]         head_q  [2];
  logic [PW-1:0]         head_d  [2];
  logic [PW-1:0]         tail_q  [2];
  logic [PW-1:0]         tail_d  [2];
  logic [CW-1:0]         cnt_q   [2];
  logic [CW-1:0]         cnt_d   [2];
  logic                  last_grant_q, last_grant_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [31:0]           cdb_value_q, cdb_value_d;
  logic [TW-1:0]         cdb_tag_q, cdb_tag_d;
  logic                  cdb_src_q, cdb_src_d;
  logic [PERF_WIDTH-1:0] stall_q, stall_d;

  logic          run;
  logic [1:0]    in_valid;
  logic [EW-1:0] in_entry [2];
  logic [1:0]    ready;
  logic [1:0]    nonempty;
  logic [1:0]    grant;
  logic [1:0]    push;

  always_comb begin
    run         = rdy_in && !need_flush_in;
    in_valid    = {mem_valid_in, alu_valid_in};
    in_entry[0] = {alu_value_in, alu_tag_in};
    in_entry[1] = {mem_value_in, mem_tag_in};
    for (int unsigned s = 0; s < 2; s++) begin
      // Start-of-cycle occupancy only: a full queue stays closed even while popping.
      ready[s]    = run && (cnt_q[s] < CW'(FIFO_DEPTH));
      nonempty[s] = (cnt_q[s] != '0);
      // All-ones tag means "no dependency": handshake completes but nothing is stored.
      push[s]     = in_valid[s] && ready[s] && (in_entry[s][TW-1:0] != '1);
    end
    // last_grant = 1 means LSB went last, so ALU wins a tie.
    grant[0] = run && nonempty[0] && (!nonempty[1] || last_grant_q);
    grant[1] = run && nonempty[1] && (!nonempty[0] || !last_grant_q);
  end

  always_comb begin
    buf_d        = buf_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_value_d  = cdb_value_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_src_d    = cdb_src_q;
    stall_d      = stall_q;
    if (rdy_in) begin
      if (need_flush_in) begin
        for (int unsigned s = 0; s < 2; s++) begin
          head_d[s] = '0;
          tail_d[s] = '0;
          cnt_d[s]  = '0;
        end
        cdb_valid_d = 1'b0;
      end else begin
        cdb_valid_d = |grant;
        for (int unsigned s = 0; s < 2; s++) begin
          if (push[s]) begin
            buf_d[s][tail_q[s]] = in_entry[s];
            tail_d[s]           = tail_q[s] + PW'(1);
          end
          if (grant[s]) begin
            {cdb_value_d, cdb_tag_d} = buf_q[s][head_q[s]];
            cdb_src_d                = 1'(s);
            last_grant_d             = 1'(s);
            head_d[s]                = head_q[s] + PW'(1);
          end
          cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(grant[s]);
        end
        if (((alu_valid_in && !ready[0]) || (mem_valid_in && !ready[1])) && (stall_q != '1))
          stall_d = stall_q + PERF_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      buf_q        <= '{default: '0};
      head_q       <= '{default: '0};
      tail_q       <= '{default: '0};
      cnt_q        <= '{default: '0};
      last_grant_q <= 1'b1;
      cdb_valid_q  <= 1'b0;
      cdb_value_q  <= '0;
      cdb_tag_q    <= '1;
      cdb_src_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      buf_q        <= buf_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_value_q  <= cdb_value_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_src_q    <= cdb_src_d;
      stall_q      <= stall_d;
    end
  end

  assign alu_ready_out = ready[0];
  assign mem_ready_out = ready[1];
  assign cdb_valid_out = cdb_valid_q;
  assign cdb_value_out = cdb_value_q;
  assign cdb_tag_out   = cdb_tag_q;
  assign cdb_src_out   = cdb_src_q;
  assign stall_cnt_out = stall_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int RW    = 3;
  localparam int TW    = RW + 1;
  localparam int DEPTH = 2;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, rdy, flush;
  logic          av, mv, ar, mr;
  logic [31:0]   aval, mval;
  logic [TW-1:0] atag, mtag;
  logic          cdb_valid, cdb_src;
  logic [31:0]   cdb_value;
  logic [TW-1:0] cdb_tag;
  logic [PW-1:0] stall_cnt;

  cdb_arbiter #(.ROB_SIZE_WIDTH(RW), .FIFO_DEPTH(DEPTH), .PERF_WIDTH(PW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .need_flush_in(flush),
    .alu_valid_in(av), .alu_value_in(aval), .alu_tag_in(atag), .alu_ready_out(ar),
    .mem_valid_in(mv), .mem_value_in(mval), .mem_tag_in(mtag), .mem_ready_out(mr),
    .cdb_valid_out(cdb_valid), .cdb_value_out(cdb_value), .cdb_tag_out(cdb_tag),
    .cdb_src_out(cdb_src), .stall_cnt_out(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [TW+31:0] qa[$], qm[$];
  bit             m_last;
  bit             m_valid;
  logic [31:0]    m_val;
  logic [TW-1:0]  m_tag;
  bit             m_src;
  int             m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qm.delete();
    m_last  = 1'b1;
    m_valid = 1'b0;
    m_val   = '0;
    m_tag   = '1;
    m_src   = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_outputs();
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_value", 64'(cdb_value), 64'(m_val));
    chk("cdb_tag",   64'(cdb_tag),   64'(m_tag));
    chk("cdb_src",   64'(cdb_src),   64'(m_src));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic set_in(input bit a_v, input logic [31:0] a_val, input logic [TW-1:0] a_tag,
                        input bit m_v, input logic [31:0] m_vl, input logic [TW-1:0] m_tg);
    av = a_v; aval = a_val; atag = a_tag;
    mv = m_v; mval = m_vl; mtag = m_tg;
  endtask

  // One clock: check handshakes, advance the model, then check the broadcast.
  task automatic cycle();
    bit run, ra, rm;
    int g;
    logic [TW+31:0] e;
    #1;
    run = rdy && !flush;
    ra  = run && (qa.size() < DEPTH);
    rm  = run && (qm.size() < DEPTH);
    chk("alu_ready", 64'(ar), 64'(ra));
    chk("mem_ready", 64'(mr), 64'(rm));
    if (rdy) begin
      if (flush) begin
        qa.delete();
        qm.delete();
        m_valid = 1'b0;
      end else begin
        if (((av && !ra) || (mv && !rm)) && m_stall < (1 << PW) - 1) m_stall++;
        g = -1;
        if (qa.size() > 0 && qm.size() > 0) g = m_last ? 0 : 1;
        else if (qa.size() > 0) g = 0;
        else if (qm.size() > 0) g = 1;
        m_valid = (g >= 0);
        if (g >= 0) begin
          e = (g == 0) ? qa.pop_front() : qm.pop_front();
          {m_val, m_tag} = e;
          m_src  = (g == 1);
          m_last = (g == 1);
        end
        if (av && ra && atag != '1) qa.push_back({aval, atag});
        if (mv && rm && mtag != '1) qm.push_back({mval, mtag});
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Single source: ALU {5, tag 3}
    set_in(1, 32'd5, TW'(3), 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_value", 64'(cdb_value), 64'd5);
    chk("single_tag",   64'(cdb_tag),   64'd3);
    chk("single_src",   64'(cdb_src),   64'd0);
    cycle();
    chk("single_idle", 64'(cdb_valid), 64'd0);

    // Tie alternation and full-queue backpressure
    for (int i = 0; i < 6; i++) begin
      set_in(1, 32'h100 + 32'(i), TW'(i), 1, 32'h200 + 32'(i), TW'(i + 1));
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Flush with entries queued: they must never be broadcast
    set_in(1, 32'hAAAA, TW'(1), 1, 32'hBBBB, TW'(2));
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (2) cycle();

    // rdy_in low with pending entries, including an all-ones tag push
    set_in(1, 32'h11, TW'(4), 1, 32'h22, '1);
    cycle();
    set_in(1, 32'h33, TW'(5), 1, 32'h44, TW'(6));
    cycle();
    rdy = 1'b0;
    repeat (3) cycle();
    rdy = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h300 + 32'(i), TW'(i), 1, 32'h400 + 32'(i), TW'(i + 2));
      cycle();
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    set_in(1, 32'h55, TW'(1), 1, 32'h66, TW'(2));
    cycle();
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    chk("tie_after_reset_src", 64'(cdb_src), 64'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rdy   = ($urandom_range(0, 99) < 85);
      flush = ($urandom_range(0, 99) < 5);
      set_in($urandom_range(0, 1), $urandom, TW'($urandom_range(0, (1 << TW) - 1)),
             $urandom_range(0, 1), $urandom, TW'($urandom_range(0, (1 << TW) - 1)));
      cycle();
    end
    chk("stall_saturated", 64'(stall_cnt), 64'((1 << PW) - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
